remote_cmd_tx: RTL and testbench

- Host/test-side transmitter for the 16-bit command protocol that the follower's command processor receives through its UART wrapper.
- Takes a 16-bit command with a single-cycle send strobe and serializes it on one UART line (8N1, LSB first).
- Sends the high byte, then the low byte, with no gap between frames.
- Raises a sticky completion flag when the second stop bit finishes.
- Contains its own baud generator and shifter; used as the RemoteComm model in the full-chip bench and as the host-side endpoint on the board.

---
 rtl/remote_cmd_tx_if.sv | 25 ++
 rtl/remote_cmd_tx.sv | 128 ++++++++++++
 tb/tb_remote_cmd_tx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/remote_cmd_tx_if.sv
// Command-side bundle of the remote command transmitter: 16-bit command,
// send strobe, serial line and status flags.
interface remote_cmd_tx_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        TX;
  logic        tx_busy;
  logic        cmd_sent;

  modport master (
    output cmd,
    output snd_cmd,
    input  TX,
    input  tx_busy,
    input  cmd_sent
  );

  modport slave (
    input  cmd,
    input  snd_cmd,
    output TX,
    output tx_busy,
    output cmd_sent
  );
endinterface

// File: rtl/remote_cmd_tx.sv
// Serializes a 16-bit command as two back-to-back 8N1 UART frames (high byte
// first, LSB first within a byte) and raises a sticky flag when both are out.
module remote_cmd_tx #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  remote_cmd_tx_if.slave    bus
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'd9;
  localparam logic [3:0]  BIT_DONE  = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX_HI = 2'd1,
    TX_LO = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [11:0] r_baud;
  logic [3:0]  r_bit;
  logic [9:0]  r_shift;
  logic [7:0]  r_lo_byte;
  logic        r_tx;
  logic        r_busy;
  logic        r_sent;

  logic        w_term;
  logic        w_hi_end;
  logic        w_lo_end;
  logic        w_accept;
  logic        w_load_lo;
  logic        w_shift;
  logic        w_done;

  assign w_term   = (r_baud == BAUD_LAST);
  assign w_hi_end = (r_state == TX_HI) && w_term && (r_bit == LAST_BIT);
  // The low stop bit is shifted out like a data bit; completion is taken one
  // clock later so it coincides with the end of that bit on the registered TX.
  assign w_lo_end = (r_state == TX_LO) && (r_bit == BIT_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.snd_cmd) w_state_nxt = TX_HI;
      TX_HI:   if (w_hi_end)    w_state_nxt = TX_LO;
      TX_LO:   if (w_lo_end)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept  = 1'b0;
    w_load_lo = 1'b0;
    w_shift   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE:    w_accept  = bus.snd_cmd;
      TX_HI: begin
        w_load_lo = w_hi_end;
        w_shift   = w_term && !w_hi_end;
      end
      TX_LO: begin
        w_done    = w_lo_end;
        w_shift   = w_term && !w_lo_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '1;
      r_lo_byte <= '0;
      r_busy    <= 1'b0;
      r_sent    <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= {1'b1, bus.cmd[15:8], 1'b0};
      r_lo_byte <= bus.cmd[7:0];
      r_baud    <= '0;
      r_bit     <= '0;
      r_busy    <= 1'b1;
      r_sent    <= 1'b0;
    end else if (w_load_lo) begin
      r_shift   <= {1'b1, r_lo_byte, 1'b0};
      r_baud    <= '0;
      r_bit     <= '0;
    end else if (w_shift) begin
      r_shift   <= {1'b1, r_shift[9:1]};
      r_baud    <= '0;
      r_bit     <= r_bit + 4'd1;
    end else if (w_done) begin
      r_baud    <= '0;
      r_bit     <= '0;
      r_busy    <= 1'b0;
      r_sent    <= 1'b1;
    end else if (r_state != IDLE) begin
      r_baud    <= r_baud + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= r_shift[0];
    end
  end

  assign bus.TX       = r_tx;
  assign bus.tx_busy  = r_busy;
  assign bus.cmd_sent = r_sent;

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Bench for remote_cmd_tx: directed commands, a line-decoding monitor that
// checks each received 16-bit command against a queue of expected values.
module tb_remote_cmd_tx;

  localparam int unsigned BD = 16;

  logic clk = 1'b0;
  logic rst_n;

  remote_cmd_tx_if bus ();

  remote_cmd_tx #(.BAUD_DIV(BD)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned rst_cnt  = 0;
  logic [15:0] exp_q[$];
  int unsigned hi_starts[$];

  always @(posedge clk) cyc++;
  always @(negedge rst_n) rst_cnt++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // ---------------- monitor: decode the serial line ----------------
  task automatic rx_byte(output logic [7:0] b, output int unsigned t, output logic ok);
    int unsigned r0;
    b  = '0;
    t  = 0;
    ok = 1'b0;
    do @(negedge clk); while (bus.TX !== 1'b0 || rst_n !== 1'b1);
    t  = cyc;
    r0 = rst_cnt;
    repeat (BD / 2) @(negedge clk);
    if (rst_cnt != r0) return;
    chk("start_bit", {31'd0, bus.TX}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      if (rst_cnt != r0) return;
      b[i] = bus.TX;
    end
    repeat (BD) @(negedge clk);
    if (rst_cnt != r0) return;
    chk("stop_bit", {31'd0, bus.TX}, 32'd1);
    ok = 1'b1;
  endtask

  initial begin : monitor
    logic [7:0]  hi, lo;
    logic [15:0] exp_v;
    int unsigned t_hi, t_lo;
    logic        ok_hi, ok_lo;
    forever begin
      rx_byte(hi, t_hi, ok_hi);
      if (!ok_hi) continue;
      rx_byte(lo, t_lo, ok_lo);
      if (!ok_lo) continue;
      hi_starts.push_back(t_hi);
      chk("byte_gap", t_lo - t_hi, 10 * BD);
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("rx_cmd", {16'd0, hi, lo}, {16'd0, exp_v});
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a clock edge; returns just after the accepting edge N.
  task automatic send(input logic [15:0] c);
    bus.cmd     = c;
    bus.snd_cmd = 1'b1;
    exp_q.push_back(c);
    @(posedge clk); #1;
    bus.snd_cmd = 1'b0;
  endtask

  task automatic wait_done(input int unsigned k0, output int unsigned k, output int unsigned busy_cnt);
    k        = k0;
    busy_cnt = (bus.tx_busy === 1'b1) ? 1 : 0;
    while (bus.cmd_sent !== 1'b1 && k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (bus.tx_busy === 1'b1) busy_cnt++;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned k, busy_cnt, viol, sent_hi;
    rst_n       = 1'b0;
    bus.cmd     = '0;
    bus.snd_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, bus.TX}, 32'd1);
    chk("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
    chk("rst_sent", {31'd0, bus.cmd_sent}, 32'd0);
    rst_n = 1'b1;
    viol  = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.TX !== 1'b1 || bus.tx_busy !== 1'b0 || bus.cmd_sent !== 1'b0) viol++;
    end
    chk("reset_idle", viol, 0);

    // Single command: exact latency and busy window.
    send(16'hA53C);
    chk("busy_at_N", {31'd0, bus.tx_busy}, 32'd1);
    chk("tx_high_at_N", {31'd0, bus.TX}, 32'd1);
    @(posedge clk); #1;
    chk("tx_start_N1", {31'd0, bus.TX}, 32'd0);
    wait_done(1, k, busy_cnt);
    chk("done_latency", k, 321);
    chk("busy_cycles", busy_cnt, 320);
    chk("busy_clear_at_done", {31'd0, bus.tx_busy}, 32'd0);
    chk("tx_high_at_done", {31'd0, bus.TX}, 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // Strobes while busy (mid high byte and on the completion cycle) are ignored.
    send(16'h1234);
    repeat (90) @(posedge clk);
    #1;
    bus.cmd     = 16'hFFFF;
    bus.snd_cmd = 1'b1;
    @(posedge clk); #1;
    bus.snd_cmd = 1'b0;
    repeat (229) @(posedge clk);
    #1;
    chk("not_done_N320", {31'd0, bus.cmd_sent}, 32'd0);
    bus.snd_cmd = 1'b1;
    @(posedge clk); #1;
    bus.snd_cmd = 1'b0;
    chk("done_N321", {31'd0, bus.cmd_sent}, 32'd1);
    viol = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus.TX !== 1'b1 || bus.tx_busy !== 1'b0 || bus.cmd_sent !== 1'b1) viol++;
    end
    chk("idle_after_ignore", viol, 0);

    // Three back-to-back commands sent as soon as each completes.
    send(16'h0003);
    wait_done(0, k, busy_cnt);
    chk("lb_done_0003", k, 321);
    @(posedge clk); #1;
    send(16'h0002);
    wait_done(0, k, busy_cnt);
    chk("lb_done_0002", k, 321);
    @(posedge clk); #1;
    send(16'h0001);
    wait_done(0, k, busy_cnt);
    chk("lb_done_0001", k, 321);
    repeat (10) @(posedge clk);
    #1;

    // Reset in bit 3 of the low byte aborts the frame immediately.
    send(16'h5AC3);
    repeat (214) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_tx", {31'd0, bus.TX}, 32'd1);
    chk("abort_sent", {31'd0, bus.cmd_sent}, 32'd0);
    chk("abort_busy", {31'd0, bus.tx_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(16'hC0DE);
    wait_done(0, k, busy_cnt);
    chk("after_abort_done", k, 321);
    repeat (10) @(posedge clk);
    #1;

    // Held strobe: two commands, one-cycle cmd_sent pulse between them.
    bus.cmd     = 16'h00FF;
    bus.snd_cmd = 1'b1;
    exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h00FF);
    sent_hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus.cmd_sent === 1'b1) sent_hi++;
    end
    bus.snd_cmd = 1'b0;
    chk("held_sent_pulse", sent_hi, 1);
    wait_done(0, k, busy_cnt);
    chk("held_done", {31'd0, bus.cmd_sent}, 32'd1);
    repeat (200) @(posedge clk);
    #1;
    if (hi_starts.size() >= 2)
      chk("held_cmd_spacing", hi_starts[hi_starts.size() - 1] - hi_starts[hi_starts.size() - 2], 20 * BD + 2);
    else
      chk("held_cmd_count", hi_starts.size(), 2);
    chk("held_idle_tx", {31'd0, bus.TX}, 32'd1);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
